// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: valid/ready handshake, trap/branch/return redirects, alignment check,
// saturating redirect counter. Optional return-address stack enabled by defining PC_RAS_EN.
module pc_sequencer #(
    parameter int                 WIDTH        = 32,
    parameter int                 STEP         = 1,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   TRAP_VECTOR  = WIDTH'(32'h00000100),
    parameter int                 ALIGN_BITS   = 0,
    parameter int                 RAS_DEPTH    = 4,
    parameter int                 CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [WIDTH-1:0]     pc,
    output logic                 pc_valid,
    input  logic                 pc_ready,
    input  logic                 branch_en,
    input  logic [WIDTH-1:0]     branch_target,
    input  logic                 trap_en,
    input  logic                 call_en,
    input  logic                 ret_en,
    output logic                 misalign,
    output logic                 ras_empty,
    output logic [CNT_WIDTH-1:0] redirect_count
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [WIDTH-1:0] pc_step;
    logic [WIDTH-1:0] ret_addr;
    logic             do_ret;

    assign pc_step = pc + WIDTH'(STEP);

`ifdef PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int OCC_W = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0] top, top_inc, top_dec;
    logic [OCC_W-1:0] occ;
    logic             do_push;

    // top indexes the most recent entry; a push when full lands on the oldest slot
    assign top_inc   = (top == PTR_W'(RAS_DEPTH - 1)) ? '0 : top + 1'b1;
    assign top_dec   = (top == '0) ? PTR_W'(RAS_DEPTH - 1) : top - 1'b1;
    assign ras_empty = (occ == '0);
    assign ret_addr  = stack[top];
    assign do_ret    = ret_en && !trap_en && !branch_en && !ras_empty;
    assign do_push   = call_en && !trap_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top <= '0;
            occ <= '0;
        end else if (do_ret && !do_push) begin
            top <= top_dec;
            occ <= occ - 1'b1;
        end else if (do_push && !do_ret) begin
            top <= top_inc;
            if (occ != OCC_W'(RAS_DEPTH)) occ <= occ + 1'b1;
        end
    end

    // pop-then-push rewrites the current top in place
    always_ff @(posedge clk) begin
        if (do_push) stack[do_ret ? top : top_inc] <= pc_step;
    end
`else
    logic unused_ras;
    assign unused_ras = ^{call_en, ret_en};
    assign ras_empty  = 1'b1;
    assign ret_addr   = '0;
    assign do_ret     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc             <= RESET_VECTOR;
            pc_valid       <= 1'b0;
            misalign       <= 1'b0;
            redirect_count <= '0;
        end else begin
            pc_valid <= 1'b1;
            misalign <= 1'b0;
            if ((trap_en || branch_en || do_ret) && (redirect_count != '1))
                redirect_count <= redirect_count + 1'b1;
            if (trap_en) begin
                pc <= TRAP_VECTOR;
            end else if (branch_en) begin
                pc       <= branch_target & ~ALIGN_MASK;
                misalign <= |(branch_target & ALIGN_MASK);
            end else if (do_ret) begin
                pc <= ret_addr;
            end else if (pc_valid && pc_ready) begin
                pc <= pc_step;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two configurations share one stimulus stream and are checked every
// cycle against a queue-based reference model, plus hand-computed literal expectations.
module tb_pc_sequencer;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic pc_ready, branch_en, trap_en, call_en, ret_en;
    logic [31:0] target;

    logic [31:0] pc0;  logic v0, mis0, re0; logic [15:0] cnt0;
    logic [7:0]  pc1;  logic v1, mis1, re1; logic [2:0]  cnt1;

    always #5 clk = ~clk;

    pc_sequencer #(.WIDTH(32), .STEP(4), .RESET_VECTOR(32'h0), .TRAP_VECTOR(32'h100),
                   .ALIGN_BITS(2), .RAS_DEPTH(2), .CNT_WIDTH(16)) d0 (
        .clk(clk), .rst(rst), .pc(pc0), .pc_valid(v0), .pc_ready(pc_ready),
        .branch_en(branch_en), .branch_target(target), .trap_en(trap_en),
        .call_en(call_en), .ret_en(ret_en), .misalign(mis0), .ras_empty(re0),
        .redirect_count(cnt0));

    pc_sequencer #(.WIDTH(8), .STEP(1), .RESET_VECTOR(8'hFC), .TRAP_VECTOR(8'h80),
                   .ALIGN_BITS(0), .RAS_DEPTH(2), .CNT_WIDTH(3)) d1 (
        .clk(clk), .rst(rst), .pc(pc1), .pc_valid(v1), .pc_ready(pc_ready),
        .branch_en(branch_en), .branch_target(target[7:0]), .trap_en(trap_en),
        .call_en(call_en), .ret_en(ret_en), .misalign(mis1), .ras_empty(re1),
        .redirect_count(cnt1));

    int passed = 0;
    int total  = 0;
    bit started = 0;

    task automatic check(string name, longint unsigned act, longint unsigned exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // reference model: per-configuration constants and state
    int              mw[2]    = '{32, 8};
    longint unsigned mst[2]   = '{4, 1};
    longint unsigned mrv[2]   = '{64'h0, 64'hFC};
    longint unsigned mtv[2]   = '{64'h100, 64'h80};
    int              mal[2]   = '{2, 0};
    longint unsigned mcmax[2] = '{64'hFFFF, 64'h7};
    longint unsigned mpc[2], mcnt[2];
    bit              mval[2], mmis[2];
    longint unsigned q0[$], q1[$];

    function automatic int qsize(int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic push(int i, longint unsigned v);
        if (i == 0) begin q0.push_back(v); if (q0.size() > 2) q0.delete(0); end
        else        begin q1.push_back(v); if (q1.size() > 2) q1.delete(0); end
    endtask

    task automatic pop(int i, output longint unsigned v);
        if (i == 0) v = q0.pop_back(); else v = q1.pop_back();
    endtask

    task automatic model_step(int i);
        longint unsigned m, am, seq, nxt, t;
        bit redir;
        m   = (64'd1 << mw[i]) - 1;
        am  = (64'd1 << mal[i]) - 1;
        t   = longint'(target) & m;
        seq = (mpc[i] + mst[i]) & m;
        nxt = mpc[i];
        redir = 0;
        mmis[i] = 0;
        if (trap_en) begin
            nxt = mtv[i]; redir = 1;
        end else if (branch_en) begin
            nxt = t & ~am; mmis[i] = (t & am) != 0; redir = 1;
            if (RAS && call_en) push(i, seq);
        end else if (RAS && ret_en && qsize(i) > 0) begin
            pop(i, nxt); redir = 1;
            if (call_en) push(i, seq);
        end else begin
            if (RAS && call_en) push(i, seq);
            if (mval[i] && pc_ready) nxt = seq;
        end
        if (redir && mcnt[i] < mcmax[i]) mcnt[i]++;
        mpc[i]  = nxt;
        mval[i] = 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mpc[i] = mrv[i]; mval[i] = 0; mmis[i] = 0; mcnt[i] = 0;
            end
            q0.delete(); q1.delete();
        end else begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("pc0", pc0, mpc[0]);       check("pc1", pc1, mpc[1]);
            check("valid0", v0, mval[0]);    check("valid1", v1, mval[1]);
            check("misalign0", mis0, mmis[0]); check("misalign1", mis1, mmis[1]);
            check("count0", cnt0, mcnt[0]);  check("count1", cnt1, mcnt[1]);
            check("ras_empty0", re0, qsize(0) == 0); check("ras_empty1", re1, qsize(1) == 0);
        end
    end

    task automatic drive(bit br, bit tr, bit ca, bit re, bit rdy, logic [31:0] tgt);
        branch_en = br; trap_en = tr; call_en = ca; ret_en = re; pc_ready = rdy; target = tgt;
        @(posedge clk); #1;
        branch_en = 0; trap_en = 0; call_en = 0; ret_en = 0; pc_ready = 0;
    endtask

    initial begin
        rst = 1; pc_ready = 0; branch_en = 0; trap_en = 0; call_en = 0; ret_en = 0; target = 0;
        #12 rst = 0; started = 1;
        drive(0, 0, 0, 0, 0, 0);
        check("lit_first_pc", pc0, 32'h0); check("lit_first_valid", v0, 1);
        // sequential fetch, stall, 8-bit wrap
        repeat (3) drive(0, 0, 0, 0, 1, 0);
        check("lit_seq_pc0", pc0, 32'hC); check("lit_seq_pc1", pc1, 8'hFF);
        repeat (2) drive(0, 0, 0, 0, 0, 0);
        check("lit_hold_pc0", pc0, 32'hC);
        drive(0, 0, 0, 0, 1, 0);
        check("lit_wrap_pc1", pc1, 8'h00); check("lit_after_hold_pc0", pc0, 32'h10);
        // asynchronous reset mid-cycle
        #2 rst = 1;
        #1 check("lit_rst_pc0", pc0, 32'h0); check("lit_rst_valid0", v0, 0);
        check("lit_rst_pc1", pc1, 8'hFC); check("lit_rst_empty1", re1, 1);
        #2 rst = 0;
        drive(0, 0, 0, 0, 0, 0);
        check("lit_post_rst_valid", v0, 1); check("lit_post_rst_pc", pc0, 32'h0);
        // trap beats branch; aligned load with misalign pulse
        drive(1, 1, 0, 0, 0, 32'h40);
        check("lit_trap_pc0", pc0, 32'h100); check("lit_trap_cnt0", cnt0, 1);
        check("lit_trap_pc1", pc1, 8'h80);
        drive(1, 0, 0, 0, 0, 32'h43);
        check("lit_align_pc0", pc0, 32'h40); check("lit_mis_pulse", mis0, 1);
        check("lit_noalign_pc1", pc1, 8'h43); check("lit_noalign_mis1", mis1, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("lit_mis_clear", mis0, 0);
        // calls with branch, overflow of a 2-deep stack, returns
        drive(1, 0, 0, 0, 0, 32'h10);
        drive(1, 0, 1, 0, 0, 32'h20);
        drive(1, 0, 1, 0, 0, 32'h30);
        drive(1, 0, 1, 0, 0, 32'h40);
        drive(0, 0, 0, 1, 0, 0);
        check("lit_ret1_pc1", pc1, RAS ? 8'h31 : 8'h40);
        drive(0, 0, 0, 1, 0, 0);
        check("lit_ret2_pc1", pc1, RAS ? 8'h21 : 8'h40);
        check("lit_ret2_pc0", pc0, RAS ? 32'h24 : 32'h40);
        drive(0, 0, 0, 1, 0, 0);
        check("lit_ret3_pc1", pc1, RAS ? 8'h21 : 8'h40); check("lit_ret3_empty", re1, 1);
        check("lit_cnt1", cnt1, RAS ? 7 : 6);
        drive(1, 0, 0, 0, 0, 32'h50);
        check("lit_cnt1_sat", cnt1, 7); check("lit_cnt0", cnt0, RAS ? 9 : 7);
        // ret on empty stack with ready: plain sequential step
        drive(0, 0, 0, 1, 1, 0);
        check("lit_ret_empty_pc1", pc1, 8'h51); check("lit_ret_empty_pc0", pc0, 32'h54);
        check("lit_ret_empty_cnt0", cnt0, RAS ? 9 : 7); check("lit_ret_empty_re", re1, 1);
        // plain call, call+ret replacing top, final ret
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 1, 0, 0);
        check("lit_callret_pc1", pc1, RAS ? 8'h53 : 8'h52); check("lit_callret_empty", re1, 1);
        drive(0, 1, 1, 0, 0, 0);
        check("lit_trapcall_empty", re1, 1); check("lit_trapcall_pc1", pc1, 8'h80);
        // mixed traffic checked by the model only
        for (int k = 0; k < 40; k++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom);
        end
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
